// File: rtl/carry_lookahead_adder.sv
// rtl/carry_lookahead_adder.sv - registered two's-complement CLA adder/subtractor
//
// cla4_block: one 4-bit carry-lookahead block with flattened carries.
//   a, bx   : operand A nibble and conditioned operand B nibble
//   cin     : carry into bit 0 of the block
//   sum     : 4-bit sum of the block
//   g_grp   : group generate of the block
//   p_grp   : group propagate of the block
//
// carry_lookahead_adder: top level, WIDTH must be a positive multiple of 4.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : A, B, M are valid this cycle
//   A, B      : two's-complement operands
//   M         : 0 = A+B, 1 = A-B
//   S         : registered sum/difference (modulo 2^WIDTH)
//   C         : registered carry-out of the MSB (subtract: 1 = no borrow)
//   V         : registered signed overflow
//   out_valid : S/C/V hold a result issued on the previous edge

module cla4_block (
  input  logic [3:0] a,
  input  logic [3:0] bx,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       g_grp,
  output logic       p_grp
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g = a & bx;
  assign p = a ^ bx;

  // Every carry is a two-level sum of products of g, p and cin.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

  assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign p_grp = &p;

endmodule

module carry_lookahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             out_valid
);

  localparam int NB = WIDTH / 4;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum_c;
  logic [NB-1:0]    g_blk;
  logic [NB-1:0]    p_blk;
  logic [NB:0]      blk_c;
  logic             c_out;
  logic             c_msb;
  logic             v_c;

  // Subtract is A + ~B + 1: invert B and feed M in as the carry-in.
  assign bx = B ^ {WIDTH{M}};

  // Second-level lookahead: carry into block k as a flat sum of products
  // over the (G,P) pairs of blocks 0..k-1 and c0, never from carry k-1.
  function automatic logic block_carry(input logic [NB-1:0] g,
                                       input logic [NB-1:0] p,
                                       input logic          c0,
                                       input int            k);
    logic c;
    logic prod;
    c = c0;
    for (int m = 0; m < k; m++) c = c & p[m];
    for (int j = 0; j < k; j++) begin
      prod = g[j];
      for (int m = j + 1; m < k; m++) prod = prod & p[m];
      c = c | prod;
    end
    return c;
  endfunction

  always_comb begin
    blk_c = '0;
    for (int k = 0; k <= NB; k++) blk_c[k] = block_carry(g_blk, p_blk, M, k);
  end

  for (genvar k = 0; k < NB; k++) begin : g_blocks
    cla4_block u_blk (
      .a     (A[4*k +: 4]),
      .bx    (bx[4*k +: 4]),
      .cin   (blk_c[k]),
      .sum   (sum_c[4*k +: 4]),
      .g_grp (g_blk[k]),
      .p_grp (p_blk[k])
    );
  end

  assign c_out = blk_c[NB];
  // Carry into the MSB recovered from its sum bit: sum = p ^ c, so c = p ^ sum.
  assign c_msb = A[WIDTH-1] ^ bx[WIDTH-1] ^ sum_c[WIDTH-1];
  assign v_c   = c_out ^ c_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= '0;
      C         <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      S         <= sum_c;
      C         <= c_out;
      V         <= v_c;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// tb/tb_carry_lookahead_adder.sv - self-checking bench for carry_lookahead_adder
module tb_carry_lookahead_adder;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;

  logic [3:0]  a4, b4, s4;
  logic [7:0]  a8, b8, s8;
  logic [15:0] a16, b16, s16;
  logic        m4, m8, m16;
  logic        c4, v4, ov4;
  logic        c8, v8, ov8;
  logic        c16, v16, ov16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  carry_lookahead_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a4), .B(b4), .M(m4),
    .S(s4), .C(c4), .V(v4), .out_valid(ov4));
  carry_lookahead_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a8), .B(b8), .M(m8),
    .S(s8), .C(c8), .V(v8), .out_valid(ov8));
  carry_lookahead_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a16), .B(b16), .M(m16),
    .S(s16), .C(c16), .V(v16), .out_valid(ov16));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [3:0] s;
    logic       c;
    logic       v;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: signed arithmetic on integers, then reduce to WIDTH bits.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit m, output longint s, output bit c,
                                output bit v);
    longint full, half, sa, sb, res;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    res  = m ? sa - sb : sa + sb;
    v    = (res >= half) || (res < -half);
    s    = ((res % full) + full) % full;
    c    = m ? (a >= b) : ((a + b) >= full);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint es;
    bit ec, ev;

    tbl[0]  = '{4'b0000, 4'b1110, 1'b0, 4'b1110, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 4'b1111, 1'b0, 4'b1111, 1'b0, 1'b0};
    tbl[2]  = '{4'b1011, 4'b0111, 1'b0, 4'b0010, 1'b1, 1'b0};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0};
    tbl[4]  = '{4'b1011, 4'b1000, 1'b0, 4'b0011, 1'b1, 1'b1};
    tbl[5]  = '{4'b0111, 4'b1011, 1'b1, 4'b1100, 1'b0, 1'b1};
    tbl[6]  = '{4'b1001, 4'b1010, 1'b1, 4'b1111, 1'b0, 1'b0};
    tbl[7]  = '{4'b1011, 4'b1010, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[8]  = '{4'b1101, 4'b1001, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[9]  = '{4'b1111, 4'b0111, 1'b1, 4'b1000, 1'b1, 1'b0};
    tbl[10] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};

    a8 = '0; b8 = '0; m8 = 1'b0;
    a16 = '0; b16 = '0; m16 = 1'b0;

    // Reset wins over a valid operation on the same edge.
    rst = 1'b1; in_valid = 1'b1; a4 = 4'b1111; b4 = 4'b1111; m4 = 1'b0;
    tick();
    chk("reset_S", 32'(s4), 32'h0);
    chk("reset_C", 32'(c4), 32'h0);
    chk("reset_V", 32'(v4), 32'h0);
    chk("reset_out_valid", 32'(ov4), 32'h0);
    chk("reset_out_valid16", 32'(ov16), 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a4 = tbl[i].a; b4 = tbl[i].b; m4 = tbl[i].m; in_valid = 1'b1;
      tick();
      chk($sformatf("tbl%0d_S", i), 32'(s4), 32'(tbl[i].s));
      chk($sformatf("tbl%0d_C", i), 32'(c4), 32'(tbl[i].c));
      chk($sformatf("tbl%0d_V", i), 32'(v4), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_ov", i), 32'(ov4), 32'h1);
    end

    // Back-to-back: output lags input by exactly one edge.
    for (int i = 2; i < 5; i++) begin
      a4 = tbl[i].a; b4 = tbl[i].b; m4 = tbl[i].m; in_valid = 1'b1;
      chk($sformatf("pipe%0d_before", i), 32'(s4), 32'(tbl[(i == 2) ? 11 : i - 1].s));
      tick();
      chk($sformatf("pipe%0d_S", i), 32'(s4), 32'(tbl[i].s));
      chk($sformatf("pipe%0d_CV", i), {30'd0, c4, v4}, {30'd0, tbl[i].c, tbl[i].v});
    end

    // Drop in_valid: out_valid falls, result held for two idle cycles.
    in_valid = 1'b0; a4 = 4'b0101; b4 = 4'b0011; m4 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold_ov", 32'(ov4), 32'h0);
      chk("hold_S", 32'(s4), 32'(tbl[4].s));
      chk("hold_CV", {30'd0, c4, v4}, {30'd0, tbl[4].c, tbl[4].v});
    end

    // Mid-stream reset discards the operation presented with it.
    in_valid = 1'b1; rst = 1'b1;
    tick();
    chk("midrst_S", 32'(s4), 32'h0);
    chk("midrst_ov", 32'(ov4), 32'h0);
    rst = 1'b0;

    // WIDTH=16 boundaries.
    a16 = 16'h7FFF; b16 = 16'h0001; m16 = 1'b0; in_valid = 1'b1;
    tick();
    chk("w16_ovf_S", 32'(s16), 32'h8000);
    chk("w16_ovf_CV", {30'd0, c16, v16}, 32'b01);
    a16 = 16'h0000; b16 = 16'h0001; m16 = 1'b1;
    tick();
    chk("w16_borrow_S", 32'(s16), 32'hFFFF);
    chk("w16_borrow_CV", {30'd0, c16, v16}, 32'b00);

    // Randomised against the arithmetic model for all three widths.
    for (int i = 0; i < 300; i++) begin
      a4  = 4'($urandom);  b4  = 4'($urandom);  m4  = 1'($urandom);
      a8  = 8'($urandom);  b8  = 8'($urandom);  m8  = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom);
      in_valid = 1'b1;
      tick();
      model(4, longint'(a4), longint'(b4), m4, es, ec, ev);
      chk("rnd4", {12'd0, ov4, c4, v4, s4, 13'd0}, {12'd0, 1'b1, ec, ev, 4'(es), 13'd0});
      model(8, longint'(a8), longint'(b8), m8, es, ec, ev);
      chk("rnd8", {ov8, c8, v8, 8'd0, s8, 13'd0}, {1'b1, ec, ev, 8'd0, 8'(es), 13'd0});
      model(16, longint'(a16), longint'(b16), m16, es, ec, ev);
      chk("rnd16", {ov16, c16, v16, 13'd0, s16}, {1'b1, ec, ev, 13'd0, 16'(es)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carry_lookahead_adder.md
Name: carry_lookahead_adder

Overview:
Registered two's-complement adder/subtractor built on carry-lookahead logic. Mode input M selects the operation: A+B when M=0, A−B when M=1. It produces the sum/difference, a carry-out and a signed-overflow flag one clock after operands are presented. It serves as the arithmetic leaf for datapath ALUs.

Parameters:
WIDTH, 4, operand/result width in bits; must be a positive multiple of 4.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands A, B, M are valid this cycle
A  input  WIDTH  operand A (two's complement)
B  input  WIDTH  operand B (two's complement)
M  input  1  mode: 0 = add, 1 = subtract (A−B)
S  output  WIDTH  registered sum/difference
C  output  1  registered carry-out of MSB (subtract: 1 = no borrow)
V  output  1  registered signed overflow
out_valid  output  1  S/C/V hold a result computed from an in_valid cycle

Behaviour:
- Operand conditioning: Bx[i] = B[i] XOR M; carry-in c0 = M. Subtract is A + ~B + 1.
- Bit level: g[i] = A[i]&Bx[i]; p[i] = A[i]^Bx[i]; sum[i] = p[i]^c[i].
- 4-bit CLA block with flattened carries: c1=g0|p0c0; c2=g1|p1g0|p1p0c0; c3 and c4 expanded likewise. No ripple inside a block.
- Each block exports group generate G = g3|p3g2|p3p2g1|p3p2p1g0 and group propagate P = p3p2p1p0.
- For WIDTH>4, a second-level lookahead unit derives each block's carry-in from (G,P) pairs and c0.
- A ripple chain between blocks is not permitted.
- C = c[WIDTH]. V = c[WIDTH] XOR c[WIDTH−1].
- Timing: combinational result sampled on a rising clk when in_valid=1. S, C, V and out_valid=1 appear after that edge (latency 1).
- When in_valid=0 at a rising edge: S/C/V hold their previous values and out_valid goes to 0.
- Throughput: one operation per cycle. Back-to-back in_valid cycles each produce a result on the following cycle.
- Reset: when rst=1 at a rising edge, S=0, C=0, V=0, out_valid=0.
- Reset has priority over in_valid on the same edge, so an operation issued on that edge is discarded.
- Reset deasserted: the first operation needs in_valid high on or after the first edge with rst=0.
- Wrap-around: the result is modulo 2^WIDTH. Overflow is reported only through V; S is never saturated.
- M is sampled together with A/B and has no state across cycles.

Test Plan:
- Reset: hold rst=1 with in_valid=1, A=4'b1111, B=4'b1111 -> after edge S=0000, C=0, V=0, out_valid=0.
- Add, no overflow (M=0): 0000+1110 -> S=1110 C=0 V=0; 0000+1111 -> 1111 C=0 V=0; 1011+0111 -> 0010 C=1 V=0; 1111+1111 -> 1110 C=1 V=0.
- Add overflow: 1011+1000 (−5+−8) -> S=0011 C=1 V=1.
- Subtract (M=1): 0111−1011 -> S=1100 C=0 V=1; 1001−1010 -> 1111 C=0 V=0; 1011−1010 -> 0001 C=1 V=0; 1101−1001 -> 0100 C=1 V=0; 1111−0111 -> 1000 C=1 V=0; 1111−1111 -> 0000 C=1 V=0; 0000−0000 -> 0000 C=1 V=0.
- Pipelining and hold: three consecutive in_valid vectors each appear exactly one cycle later. Drop in_valid -> out_valid=0 next cycle and S/C/V unchanged.
- Width scaling: WIDTH=16, 7FFF+0001 -> 8000 C=0 V=1; 0000−0001 -> FFFF C=0 V=0. Randomised compare against the behavioural A±B reference for WIDTH=4, 8 and 16.
